hazard_ctrl: RTL and testbench

Pipeline hazard and sequencing controller for the 5-stage MIPS core. It drives the enable and clear inputs of the PC, IF/ID and ID/EX pipeline registers. It resolves load-use hazards by stalling, taken branches by flushing, and multi-cycle multiply/divide by stalling dependent instructions. It also sequences the shared multiply/divide unit (MDU) and keeps a free-running stall counter for performance monitoring.

---
 rtl/hazard_pkg.sv | 19 +
 rtl/mdu_seq.sv | 87 ++++++++
 rtl/hazard_ctrl.sv | 92 +++++++++
 tb/tb_hazard_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings and defaults for the pipeline hazard controller.
// Holds the MDU op classes, the MDU sequencer state enum and default latencies.
package hazard_pkg;

  localparam logic [1:0] MDU_NONE = 2'b00;
  localparam logic [1:0] MDU_MUL  = 2'b01;
  localparam logic [1:0] MDU_DIV  = 2'b10;
  localparam logic [1:0] MDU_HILO = 2'b11;

  localparam int DEF_MUL_LAT = 4;
  localparam int DEF_DIV_LAT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } mdu_state_e;

endpackage

// File: rtl/mdu_seq.sv
// Multiply/divide unit sequencer: start pulse, latency countdown and HI/LO write strobe.
// The first RUN cycle is recognised by the countdown still holding its loaded latency.
module mdu_seq
  import hazard_pkg::*;
#(
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int DIV_LAT = DEF_DIV_LAT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_issue,
  input  logic i_issue_div,
  output logic o_start,
  output logic o_is_div,
  output logic o_hilo_we,
  output logic o_busy
);

  localparam int CW = $clog2(DIV_LAT + 1);
  localparam logic [CW-1:0] MUL_CNT = CW'(MUL_LAT);
  localparam logic [CW-1:0] DIV_CNT = CW'(DIV_LAT);

  mdu_state_e    r_state;
  mdu_state_e    w_next_state;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_next_cnt;
  logic          r_is_div;
  logic          w_next_is_div;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_cnt    <= w_next_cnt;
      r_is_div <= w_next_is_div;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_next_cnt    = r_cnt;
    w_next_is_div = r_is_div;
    o_start       = 1'b0;
    o_is_div      = 1'b0;
    o_hilo_we     = 1'b0;
    o_busy        = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_issue) begin
          w_next_state  = RUN;
          w_next_cnt    = i_issue_div ? DIV_CNT : MUL_CNT;
          w_next_is_div = i_issue_div;
        end
      end
      RUN: begin
        o_busy     = 1'b1;
        o_start    = (r_cnt == (r_is_div ? DIV_CNT : MUL_CNT));
        o_is_div   = o_start & r_is_div;
        w_next_cnt = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        o_busy       = 1'b1;
        o_hilo_we    = 1'b1;
        w_next_cnt   = '0;
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
        w_next_cnt   = '0;
      end
    endcase
    // Outputs are forced quiet during reset, before the state register has settled.
    if (rst) begin
      o_start   = 1'b0;
      o_is_div  = 1'b0;
      o_hilo_we = 1'b0;
      o_busy    = 1'b0;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use and MDU stalls, branch flushes and a stall counter.
// Priority is branch flush over stall over advance; the MDU sequencer is a sub-module.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int DIV_LAT = DEF_DIV_LAT,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [1:0]        id_mdu_op,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_branch_taken,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              ifid_clr,
  output logic              idex_clr,
  output logic              mdu_start,
  output logic              mdu_is_div,
  output logic              hilo_we,
  output logic              mdu_busy,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic             w_lu;
  logic             w_mh;
  logic             w_stall;
  logic             w_issue;
  logic             w_busy;
  logic [CNT_W-1:0] r_stall_cnt;

  assign w_lu = ex_mem_read && (ex_rd != '0) &&
                ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));
  assign w_mh    = (id_mdu_op != MDU_NONE) && w_busy;
  assign w_stall = (w_lu || w_mh) && !ex_branch_taken;
  assign w_issue = !rst && !ex_branch_taken && !w_stall &&
                   ((id_mdu_op == MDU_MUL) || (id_mdu_op == MDU_DIV));

  mdu_seq #(
    .MUL_LAT(MUL_LAT),
    .DIV_LAT(DIV_LAT)
  ) u_mdu_seq (
    .clk        (clk),
    .rst        (rst),
    .i_issue    (w_issue),
    .i_issue_div(id_mdu_op == MDU_DIV),
    .o_start    (mdu_start),
    .o_is_div   (mdu_is_div),
    .o_hilo_we  (hilo_we),
    .o_busy     (w_busy)
  );

  assign mdu_busy = w_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;

  always_comb begin
    pc_en    = 1'b1;
    ifid_en  = 1'b1;
    ifid_clr = 1'b0;
    idex_clr = 1'b0;
    if (rst) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      ifid_clr = 1'b1;
      idex_clr = 1'b1;
    end else if (ex_branch_taken) begin
      ifid_clr = 1'b1;
      idex_clr = 1'b1;
    end else if (w_stall) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_clr = 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: reset, load-use, mult/mfhi, back-to-back div,
// branch priority and reset in the middle of a divide.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  localparam int REG_AW = 5;
  localparam int CNT_W  = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [REG_AW-1:0] id_rs, id_rt, ex_rd;
  logic              id_uses_rs, id_uses_rt, ex_mem_read, ex_branch_taken;
  logic [1:0]        id_mdu_op;
  logic              pc_en, ifid_en, ifid_clr, idex_clr;
  logic              mdu_start, mdu_is_div, hilo_we, mdu_busy;
  logic [CNT_W-1:0]  stall_cnt;

  int testsRun    = 0;
  int testsFailed = 0;
  int cyc         = 0;
  int expStall    = 0;
  int startA      = 0;
  int startB      = 0;
  int hiloSeen    = 0;

  hazard_ctrl #(
    .REG_AW (REG_AW),
    .MUL_LAT(4),
    .DIV_LAT(32),
    .CNT_W  (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_uses_rs     (id_uses_rs),
    .id_uses_rt     (id_uses_rt),
    .id_mdu_op      (id_mdu_op),
    .ex_mem_read    (ex_mem_read),
    .ex_rd          (ex_rd),
    .ex_branch_taken(ex_branch_taken),
    .pc_en          (pc_en),
    .ifid_en        (ifid_en),
    .ifid_clr       (ifid_clr),
    .idex_clr       (idex_clr),
    .mdu_start      (mdu_start),
    .mdu_is_div     (mdu_is_div),
    .hilo_we        (hilo_we),
    .mdu_busy       (mdu_busy),
    .stall_cnt      (stall_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic [REG_AW-1:0] rs, input logic [REG_AW-1:0] rt,
                               input logic urs, input logic urt, input logic [1:0] op,
                               input logic memRd, input logic [REG_AW-1:0] rd, input logic br);
    id_rs           = rs;
    id_rt           = rt;
    id_uses_rs      = urs;
    id_uses_rt      = urt;
    id_mdu_op       = op;
    ex_mem_read     = memRd;
    ex_rd           = rd;
    ex_branch_taken = br;
  endtask

  task automatic applyIdle(input logic [1:0] op);
    applyStimulus('0, '0, 1'b0, 1'b0, op, 1'b0, '0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(5'd7, 5'd0, 1'b1, 1'b0, MDU_MUL, 1'b1, 5'd7, 1'b0);
    tick();

    // Reset held with hazards present
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("rst_pc_en", pc_en, 0);
      checkOutput("rst_ifid_en", ifid_en, 0);
      checkOutput("rst_ifid_clr", ifid_clr, 1);
      checkOutput("rst_idex_clr", idex_clr, 1);
      checkOutput("rst_mdu_start", mdu_start, 0);
      checkOutput("rst_busy", mdu_busy, 0);
      checkOutput("rst_stall_cnt", stall_cnt, 0);
      tick();
    end

    rst = 1'b0;
    applyIdle(MDU_NONE);
    @(negedge clk);
    checkOutput("adv_pc_en", pc_en, 1);
    checkOutput("adv_ifid_en", ifid_en, 1);
    checkOutput("adv_ifid_clr", ifid_clr, 0);
    checkOutput("adv_idex_clr", idex_clr, 0);
    tick();

    // Load-use on rs
    applyStimulus(5'd7, 5'd0, 1'b1, 1'b0, MDU_NONE, 1'b1, 5'd7, 1'b0);
    @(negedge clk);
    checkOutput("lu_pc_en", pc_en, 0);
    checkOutput("lu_ifid_en", ifid_en, 0);
    checkOutput("lu_idex_clr", idex_clr, 1);
    checkOutput("lu_ifid_clr", ifid_clr, 0);
    tick();
    expStall = 1;
    applyIdle(MDU_NONE);
    @(negedge clk);
    checkOutput("lu_cnt", stall_cnt, expStall);
    checkOutput("lu_after_pc_en", pc_en, 1);
    tick();

    // Load to r0 never stalls
    applyStimulus(5'd0, 5'd0, 1'b1, 1'b0, MDU_NONE, 1'b1, 5'd0, 1'b0);
    @(negedge clk);
    checkOutput("lu_r0_pc_en", pc_en, 1);
    checkOutput("lu_r0_idex_clr", idex_clr, 0);
    tick();

    // Load-use on rt
    applyStimulus(5'd3, 5'd9, 1'b1, 1'b1, MDU_NONE, 1'b1, 5'd9, 1'b0);
    @(negedge clk);
    checkOutput("lu_rt_pc_en", pc_en, 0);
    tick();
    expStall = 2;

    // Matching rs that is not read
    applyStimulus(5'd7, 5'd0, 1'b0, 1'b0, MDU_NONE, 1'b1, 5'd7, 1'b0);
    @(negedge clk);
    checkOutput("lu_unused_pc_en", pc_en, 1);
    checkOutput("lu_rt_cnt", stall_cnt, expStall);
    tick();

    // Mult then dependent mfhi
    applyIdle(MDU_MUL);
    @(negedge clk);
    checkOutput("mul_issue_pc_en", pc_en, 1);
    checkOutput("mul_issue_start", mdu_start, 0);
    tick();
    for (int k = 1; k <= 6; k++) begin
      applyIdle(MDU_HILO);
      @(negedge clk);
      checkOutput($sformatf("mul_pc_en_k%0d", k), pc_en, (k <= 5) ? 0 : 1);
      checkOutput($sformatf("mul_start_k%0d", k), mdu_start, (k == 1) ? 1 : 0);
      checkOutput($sformatf("mul_is_div_k%0d", k), mdu_is_div, 0);
      checkOutput($sformatf("mul_hilo_k%0d", k), hilo_we, (k == 5) ? 1 : 0);
      checkOutput($sformatf("mul_busy_k%0d", k), mdu_busy, (k <= 5) ? 1 : 0);
      tick();
    end
    expStall = expStall + 5;
    applyIdle(MDU_NONE);
    @(negedge clk);
    checkOutput("mul_cnt", stall_cnt, expStall);
    tick();

    // Back-to-back divides
    applyIdle(MDU_DIV);
    @(negedge clk);
    checkOutput("div_issue_pc_en", pc_en, 1);
    tick();
    for (int k = 1; k <= 34; k++) begin
      applyIdle(MDU_DIV);
      @(negedge clk);
      if (k == 1) startA = cyc;
      checkOutput($sformatf("div_pc_en_k%0d", k), pc_en, (k <= 33) ? 0 : 1);
      checkOutput($sformatf("div_start_k%0d", k), mdu_start, (k == 1) ? 1 : 0);
      checkOutput($sformatf("div_hilo_k%0d", k), hilo_we, (k == 33) ? 1 : 0);
      tick();
    end
    expStall = expStall + 33;
    applyIdle(MDU_NONE);
    @(negedge clk);
    startB = cyc;
    checkOutput("div2_start", mdu_start, 1);
    checkOutput("div2_is_div", mdu_is_div, 1);
    checkOutput("div_start_gap", startB - startA, 34);
    checkOutput("div_cnt", stall_cnt, expStall);
    tick();
    for (int j = 2; j <= 33; j++) begin
      @(negedge clk);
      if (j == 33) checkOutput("div2_hilo", hilo_we, 1);
      tick();
    end
    @(negedge clk);
    checkOutput("div2_idle", mdu_busy, 0);
    tick();

    // Branch with load-use and mult in ID
    applyStimulus(5'd7, 5'd0, 1'b1, 1'b0, MDU_MUL, 1'b1, 5'd7, 1'b1);
    @(negedge clk);
    checkOutput("br_ifid_clr", ifid_clr, 1);
    checkOutput("br_idex_clr", idex_clr, 1);
    checkOutput("br_pc_en", pc_en, 1);
    checkOutput("br_ifid_en", ifid_en, 1);
    tick();
    applyIdle(MDU_NONE);
    @(negedge clk);
    checkOutput("br_no_start", mdu_start, 0);
    checkOutput("br_no_busy", mdu_busy, 0);
    checkOutput("br_cnt", stall_cnt, expStall);
    tick();

    // Branch while the MDU is running
    applyIdle(MDU_MUL);
    tick();
    applyStimulus('0, '0, 1'b0, 1'b0, MDU_HILO, 1'b0, '0, 1'b1);
    @(negedge clk);
    checkOutput("brmh_pc_en", pc_en, 1);
    checkOutput("brmh_start", mdu_start, 1);
    checkOutput("brmh_busy", mdu_busy, 1);
    tick();
    applyIdle(MDU_NONE);
    for (int j = 0; j < 4; j++) tick();
    @(negedge clk);
    checkOutput("brmh_idle", mdu_busy, 0);
    checkOutput("brmh_cnt", stall_cnt, expStall);
    tick();

    // Reset in the middle of a divide
    applyIdle(MDU_DIV);
    tick();
    applyIdle(MDU_NONE);
    for (int j = 0; j < 9; j++) tick();
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rstdiv_pc_en", pc_en, 0);
    checkOutput("rstdiv_busy", mdu_busy, 0);
    checkOutput("rstdiv_hilo", hilo_we, 0);
    tick();
    rst = 1'b0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (j == 0) begin
        checkOutput("rstdiv_after_busy", mdu_busy, 0);
        checkOutput("rstdiv_after_cnt", stall_cnt, 0);
      end
      if (hilo_we === 1'b1) hiloSeen++;
      tick();
    end
    checkOutput("rstdiv_no_hilo", hiloSeen, 0);
    applyIdle(MDU_DIV);
    @(negedge clk);
    checkOutput("rediv_pc_en", pc_en, 1);
    tick();
    applyIdle(MDU_NONE);
    @(negedge clk);
    checkOutput("rediv_start", mdu_start, 1);
    checkOutput("rediv_is_div", mdu_is_div, 1);
    checkOutput("rediv_busy", mdu_busy, 1);
    tick();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
